rggen_wishbone_bridge: RTL and testbench
========================================

# rggen_wishbone_bridge

Wishbone B4 initiator that turns one rggen register-bus request (valid/access/address/write data/strobe) into a single Wishbone cycle and returns ready/status/read data. It sits at the upstream end of a Wishbone link whose responder is a register block's Wishbone adapter, for example when an rggen-generated hierarchy forwards a window to a Wishbone subsystem. It is a single-outstanding-transfer block with optional pipelined (stall) mode, retry handling and a cycle timeout.

## Interface
- ADDRESS_WIDTH, 8: width of bus and Wishbone address.
- BUS_WIDTH, 32: data width; multiple of 8.
- USE_STALL, 1: 1 = pipelined mode (honour i_wb_stall, STB for one accepted cycle); 0 = classic mode (STB held until termination).
- RETRY_LIMIT, 3: number of RTY re-issues before failing with SLVERR; 0 = first RTY fails.
- TIMEOUT, 0: cycles in REQUEST+WAIT before abort; 0 = disabled.
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_bus_valid  in  1  request valid; held until o_bus_ready.
- i_bus_access  in  2  access type; bit 0 = write.
- i_bus_address  in  ADDRESS_WIDTH  byte address.
- i_bus_write_data  in  BUS_WIDTH  write data.
- i_bus_strobe  in  BUS_WIDTH/8  byte enables.
- o_bus_ready  out  1  one-cycle completion pulse.
- o_bus_status  out  2  00 OKAY, 10 SLVERR, 11 DECERR; valid with ready.
- o_bus_read_data  out  BUS_WIDTH  read data; valid with ready.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1  Wishbone cycle/strobe/write.
- o_wb_adr  out  ADDRESS_WIDTH; o_wb_dat  out  BUS_WIDTH; o_wb_sel  out  BUS_WIDTH/8.
- i_wb_stall, i_wb_ack, i_wb_err, i_wb_rty  in  1  Wishbone responder signals.
- i_wb_dat  in  BUS_WIDTH  read data.

## Operation
- States: IDLE, REQUEST, WAIT, BACKOFF, RESPOND; all outputs registered.
- IDLE: i_bus_valid sampled high -> latch adr/we=access[0]/dat/sel onto o_wb_*, clear retry and timeout counters, set cyc=stb=1, go REQUEST.
- Termination = ack|err|rty, sampled in REQUEST and WAIT; priority err > rty > ack when several are high.
- REQUEST, USE_STALL=1: no termination and !i_wb_stall -> stb=0, go WAIT; stall high -> stay.
- REQUEST, USE_STALL=0: stall ignored; stay until termination.
- ack: cyc=stb=0, capture i_wb_dat (reads only; writes load zero), status 00, go RESPOND.
- err: cyc=stb=0, read data 0, status 10, go RESPOND.
- rty with retry count < RETRY_LIMIT: cyc=stb=0, increment count, go BACKOFF. BACKOFF lasts one cycle with cyc low, then cyc=stb=1 with the same latched request, go REQUEST; timeout counter restarts.
- rty with count == RETRY_LIMIT: behaves as err (status 10).
- Timeout: counter of width $clog2(TIMEOUT+1) increments each REQUEST/WAIT cycle; on reaching TIMEOUT with no termination that cycle -> cyc=stb=0, status 11, data 0, go RESPOND. Termination in the same cycle wins over timeout.
- RESPOND: o_bus_ready=1 for exactly one cycle, then IDLE. i_bus_valid is ignored in RESPOND.
- o_bus_status and o_bus_read_data hold their values until the next completion.
- Responder signals outside REQUEST/WAIT are ignored (late ack does not complete anything).

## Timing
- Reset values: cyc, stb, we, ready = 0; adr, dat, sel, read data = 0; status 00; state IDLE; counters 0.
- Reset mid-transfer drops cyc/stb asynchronously; transfer is abandoned with no ready pulse.
- Minimum latency: valid at cycle 0, stb at 1, ack at 1 (zero-wait), ready at 2.
- Each stall cycle, wait state, or BACKOFF adds one cycle.
- A new request is accepted at the earliest one cycle after the ready pulse (IDLE), so there are 3 cycles minimum per transfer.
- In pipelined mode, stb is high for exactly one non-stalled cycle per issue.

## Structure
- Access and status encodings (write bit, OKAY/SLVERR/DECERR) live in the shared rggen constants package/header used by the adapters.
- State encoding stays local.
- Single module, no sub-modules; timeout and retry counters are inline.

## Test plan
- Pipelined write: valid, access 11, adr 0x10, dat 0xDEADBEEF, sel 0xF; stall for 2 cycles, ack 1 cycle after acceptance -> one stb accepted, ready 1 cycle after ack, status 00.
- Classic read (USE_STALL=0): ack with i_wb_dat 0x12345678 after 3 wait states -> stb held 4 cycles, read data 0x12345678, status 00, latency 5.
- Error: err and ack asserted together on a read -> status 10, read data 0, cyc low the next cycle.
- Retry (RETRY_LIMIT=2): rty, rty, ack -> two BACKOFF gaps with cyc low, three issues with identical adr/dat, final status 00. With three rty -> status 10 after the third.
- Timeout (TIMEOUT=8): responder silent -> cyc drops after 8 cycles, status 11, data 0. An ack on exactly cycle 8 -> status 00.
- Reset asserted while in WAIT -> cyc/stb 0 immediately, no ready pulse, a subsequent request completes normally.

Source files
------------

// File: rtl/rggen_wishbone_bridge_pkg.sv
// rggen_wishbone_bridge_pkg: rggen register-bus access and status encodings shared with the adapters
package rggen_wishbone_bridge_pkg;
   localparam int RGGEN_ACCESS_WRITE_BIT = 0;
   typedef enum logic [1:0] {
      RGGEN_OKAY        = 2'b00,
      RGGEN_EXOKAY      = 2'b01,
      RGGEN_SLAVE_ERROR = 2'b10,
      RGGEN_ERROR       = 2'b11
   } rggen_status_e;
endpackage

// File: rtl/rggen_wishbone_bridge.sv
// rggen_wishbone_bridge: single-outstanding Wishbone B4 initiator with stall, retry and timeout handling
module rggen_wishbone_bridge
   import rggen_wishbone_bridge_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32,
   parameter int USE_STALL     = 1,
   parameter int RETRY_LIMIT   = 3,
   parameter int TIMEOUT       = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_bus_valid,
   input  logic [1:0]               i_bus_access,
   input  logic [ADDRESS_WIDTH-1:0] i_bus_address,
   input  logic [BUS_WIDTH-1:0]     i_bus_write_data,
   input  logic [BUS_WIDTH/8-1:0]   i_bus_strobe,
   output logic                     o_bus_ready,
   output logic [1:0]               o_bus_status,
   output logic [BUS_WIDTH-1:0]     o_bus_read_data,
   output logic                     o_wb_cyc,
   output logic                     o_wb_stb,
   output logic                     o_wb_we,
   output logic [ADDRESS_WIDTH-1:0] o_wb_adr,
   output logic [BUS_WIDTH-1:0]     o_wb_dat,
   output logic [BUS_WIDTH/8-1:0]   o_wb_sel,
   input  logic                     i_wb_stall,
   input  logic                     i_wb_ack,
   input  logic                     i_wb_err,
   input  logic                     i_wb_rty,
   input  logic [BUS_WIDTH-1:0]     i_wb_dat
);
   localparam int RW = RETRY_LIMIT > 0 ? $clog2(RETRY_LIMIT + 1) : 1;
   localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   typedef enum logic [2:0] {IDLE, REQUEST, WAIT, BACKOFF, RESPOND} state_e;
   state_e state, state_n;
   logic [RW-1:0] retry, retry_n;
   logic [TW-1:0] tcnt, tcnt_n;
   logic cyc_n, stb_n, we_n, ready_n;
   logic [ADDRESS_WIDTH-1:0] adr_n;
   logic [BUS_WIDTH-1:0] dat_n, rdata_n;
   logic [BUS_WIDTH/8-1:0] sel_n;
   logic [1:0] status_n;
   logic term, timeout;
   assign term    = i_wb_ack | i_wb_err | i_wb_rty;
   assign timeout = TIMEOUT != 0 && tcnt + TW'(1) == TW'(TIMEOUT);
   assign ready_n = state_n == RESPOND;
   always_comb begin
      state_n  = state;
      retry_n  = retry;
      tcnt_n   = tcnt;
      cyc_n    = o_wb_cyc;
      stb_n    = o_wb_stb;
      we_n     = o_wb_we;
      adr_n    = o_wb_adr;
      dat_n    = o_wb_dat;
      sel_n    = o_wb_sel;
      status_n = o_bus_status;
      rdata_n  = o_bus_read_data;
      case (state)
         IDLE: if (i_bus_valid) begin
            state_n = REQUEST;
            cyc_n   = 1'b1;
            stb_n   = 1'b1;
            we_n    = i_bus_access[RGGEN_ACCESS_WRITE_BIT];
            adr_n   = i_bus_address;
            dat_n   = i_bus_write_data;
            sel_n   = i_bus_strobe;
            retry_n = '0;
            tcnt_n  = '0;
         end
         REQUEST, WAIT: begin
            tcnt_n = tcnt + TW'(1);
            if (term || timeout) begin
               cyc_n = 1'b0;
               stb_n = 1'b0;
               // termination in the same cycle beats timeout; err beats rty beats ack
               if (i_wb_err || (i_wb_rty && retry == RW'(RETRY_LIMIT))) begin
                  state_n  = RESPOND;
                  status_n = RGGEN_SLAVE_ERROR;
                  rdata_n  = '0;
               end else if (i_wb_rty) begin
                  state_n = BACKOFF;
                  retry_n = retry + RW'(1);
               end else if (i_wb_ack) begin
                  state_n  = RESPOND;
                  status_n = RGGEN_OKAY;
                  rdata_n  = o_wb_we ? '0 : i_wb_dat;
               end else begin
                  state_n  = RESPOND;
                  status_n = RGGEN_ERROR;
                  rdata_n  = '0;
               end
            end else if (state == REQUEST && USE_STALL != 0 && !i_wb_stall) begin
               stb_n   = 1'b0;
               state_n = WAIT;
            end
         end
         BACKOFF: begin
            state_n = REQUEST;
            cyc_n   = 1'b1;
            stb_n   = 1'b1;
            tcnt_n  = '0;
         end
         RESPOND: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         state           <= IDLE;
         retry           <= '0;
         tcnt            <= '0;
         o_wb_cyc        <= 1'b0;
         o_wb_stb        <= 1'b0;
         o_wb_we         <= 1'b0;
         o_wb_adr        <= '0;
         o_wb_dat        <= '0;
         o_wb_sel        <= '0;
         o_bus_ready     <= 1'b0;
         o_bus_status    <= RGGEN_OKAY;
         o_bus_read_data <= '0;
      end else begin
         state           <= state_n;
         retry           <= retry_n;
         tcnt            <= tcnt_n;
         o_wb_cyc        <= cyc_n;
         o_wb_stb        <= stb_n;
         o_wb_we         <= we_n;
         o_wb_adr        <= adr_n;
         o_wb_dat        <= dat_n;
         o_wb_sel        <= sel_n;
         o_bus_ready     <= ready_n;
         o_bus_status    <= status_n;
         o_bus_read_data <= rdata_n;
      end
endmodule

// File: tb/tb_rggen_wishbone_bridge.sv
// tb_rggen_wishbone_bridge: pipelined and classic bridges driven side by side against a transaction-level model
module tb_rggen_wishbone_bridge;
   localparam int AW = 8, BW = 32, SW = 4, LIMIT = 2, TMO = 8;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic valid;
   logic [1:0] access;
   logic [AW-1:0] adr;
   logic [BW-1:0] wdata, wb_rdat, rd_val;
   logic [SW-1:0] strobe;
   logic stall, ack, err, rty;
   logic ready[2], cyc[2], stb[2], we[2];
   logic [1:0] status[2];
   logic [BW-1:0] rdata[2], wdat[2];
   logic [AW-1:0] wadr[2];
   logic [SW-1:0] sel[2];
   // per-issue responder script: {err,rty,ack} asserted on cycle dd of the issue, stall for the first ss cycles
   logic [2:0] tm[4];
   int dd[4], ss[4];
   int checks = 0, failures = 0;

   rggen_wishbone_bridge #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .USE_STALL(1), .RETRY_LIMIT(LIMIT), .TIMEOUT(TMO)) u_pipe (
      .i_clk(clk), .i_rst(rst), .i_bus_valid(valid), .i_bus_access(access), .i_bus_address(adr),
      .i_bus_write_data(wdata), .i_bus_strobe(strobe), .o_bus_ready(ready[0]), .o_bus_status(status[0]),
      .o_bus_read_data(rdata[0]), .o_wb_cyc(cyc[0]), .o_wb_stb(stb[0]), .o_wb_we(we[0]), .o_wb_adr(wadr[0]),
      .o_wb_dat(wdat[0]), .o_wb_sel(sel[0]), .i_wb_stall(stall), .i_wb_ack(ack), .i_wb_err(err),
      .i_wb_rty(rty), .i_wb_dat(wb_rdat));
   rggen_wishbone_bridge #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .USE_STALL(0), .RETRY_LIMIT(LIMIT), .TIMEOUT(TMO)) u_classic (
      .i_clk(clk), .i_rst(rst), .i_bus_valid(valid), .i_bus_access(access), .i_bus_address(adr),
      .i_bus_write_data(wdata), .i_bus_strobe(strobe), .o_bus_ready(ready[1]), .o_bus_status(status[1]),
      .o_bus_read_data(rdata[1]), .o_wb_cyc(cyc[1]), .o_wb_stb(stb[1]), .o_wb_we(we[1]), .o_wb_adr(wadr[1]),
      .o_wb_dat(wdat[1]), .o_wb_sel(sel[1]), .i_wb_stall(stall), .i_wb_ack(ack), .i_wb_err(err),
      .i_wb_rty(rty), .i_wb_dat(wb_rdat));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_issue(input int i, input logic [2:0] t, input int d, input int s);
      tm[i] = t;
      dd[i] = d;
      ss[i] = s;
   endtask

   task automatic junk();
      {stall, err, rty, ack} = 4'($urandom);
      wb_rdat = $urandom;
   endtask

   task automatic run_txn(input string name);
      int lat[2], iss[2], stbs[2], bad[2], exp_stb[2];
      int k, cur, ci, exp_lat, exp_iss, retries, e;
      logic prev[2];
      logic [1:0] exp_st;
      logic [BW-1:0] exp_rd;
      bit timed, hold;
      exp_lat = 1;
      exp_iss = 0;
      exp_stb = '{0, 0};
      retries = 0;
      exp_st = 2'b00;
      exp_rd = '0;
      for (int i = 0; i <= LIMIT; i++) begin
         timed = tm[i] == 3'b000 || dd[i] >= TMO;
         e = timed ? TMO - 1 : dd[i];
         exp_iss++;
         exp_lat += e + 1;
         exp_stb[0] += (e < ss[i] ? e : ss[i]) + 1;
         exp_stb[1] += e + 1;
         if (timed) begin exp_st = 2'b11; break; end
         if (tm[i][2]) begin exp_st = 2'b10; break; end
         if (tm[i][1]) begin
            if (retries < LIMIT) begin retries++; exp_lat++; continue; end
            exp_st = 2'b10;
            break;
         end
         exp_st = 2'b00;
         exp_rd = access[0] ? '0 : rd_val;
         break;
      end
      lat = '{0, 0}; iss = '{0, 0}; stbs = '{0, 0}; bad = '{0, 0}; prev = '{1'b0, 1'b0};
      k = 0;
      cur = -1;
      hold = 1'($urandom_range(0, 1));
      valid = 1'b1;
      for (int c = 1; c <= 100 && (lat[0] == 0 || lat[1] == 0); c++) begin
         @(posedge clk);
         #1;
         for (int u = 0; u < 2; u++) begin
            if (ready[u] && lat[u] == 0) lat[u] = c;
            if (cyc[u] && !prev[u]) iss[u]++;
            if (stb[u]) stbs[u]++;
            if (cyc[u] && (wadr[u] !== adr || we[u] !== access[0] || wdat[u] !== wdata || sel[u] !== strobe)) bad[u]++;
            if ((stb[u] && !cyc[u]) || cyc[u] !== cyc[0]) bad[u]++;
         end
         if ((ready[0] || ready[1]) && !hold) valid = 1'b0;
         if (cyc[0]) begin
            if (!prev[0]) begin cur++; k = 0; end else k++;
            ci = cur > 3 ? 3 : cur;
            stall = k < ss[ci];
            {err, rty, ack} = k == dd[ci] ? tm[ci] : 3'b000;
            wb_rdat = ack ? rd_val : $urandom;
         end else junk();
         prev = cyc;
      end
      for (int u = 0; u < 2; u++) begin
         check($sformatf("%s_u%0d_latency", name, u), 64'(lat[u]), 64'(exp_lat));
         check($sformatf("%s_u%0d_issues", name, u), 64'(iss[u]), 64'(exp_iss));
         check($sformatf("%s_u%0d_stb_cycles", name, u), 64'(stbs[u]), 64'(exp_stb[u]));
         check($sformatf("%s_u%0d_wb_fields", name, u), 64'(bad[u]), 64'(0));
         check($sformatf("%s_u%0d_status", name, u), 64'(status[u]), 64'(exp_st));
         check($sformatf("%s_u%0d_rdata", name, u), 64'(rdata[u]), 64'(exp_rd));
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
      for (int u = 0; u < 2; u++) begin
         check($sformatf("%s_u%0d_ready_pulse", name, u), 64'({ready[u], cyc[u]}), 64'(0));
         check($sformatf("%s_u%0d_held", name, u), {30'd0, status[u], rdata[u]}, {30'd0, exp_st, exp_rd});
      end
   endtask

   task automatic reset_mid();
      int readies;
      access = 2'b00;
      adr = 8'h5A;
      for (int i = 0; i < 4; i++) set_issue(i, 3'b000, 20, 0);
      valid = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         {stall, err, rty, ack} = 4'b0000;
      end
      for (int u = 0; u < 2; u++) check($sformatf("rst_mid_u%0d_pre", u), 64'(cyc[u]), 64'(1));
      #2 rst = 1'b1;
      #1;
      for (int u = 0; u < 2; u++) check($sformatf("rst_mid_u%0d_async", u), 64'({cyc[u], stb[u]}), 64'(0));
      valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      readies = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         for (int u = 0; u < 2; u++) readies += int'(ready[u]) + int'(cyc[u]);
      end
      check("rst_mid_no_ready", 64'(readies), 64'(0));
   endtask

   initial begin
      valid = 1'b0; access = '0; adr = '0; wdata = '0; strobe = '0;
      {stall, ack, err, rty} = 4'b0000; wb_rdat = '0; rd_val = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         check($sformatf("reset_u%0d_ctl", u), 64'({cyc[u], stb[u], we[u], ready[u], status[u]}), 64'(0));
         check($sformatf("reset_u%0d_adr_sel", u), 64'({wadr[u], sel[u]}), 64'(0));
         check($sformatf("reset_u%0d_dat", u), 64'(wdat[u]), 64'(0));
         check($sformatf("reset_u%0d_rdata", u), 64'(rdata[u]), 64'(0));
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      access = 2'b11; adr = 8'h10; wdata = 32'hDEADBEEF; strobe = 4'hF; rd_val = 32'hCAFEF00D;
      set_issue(0, 3'b001, 3, 2);
      run_txn("pipe_write");
      access = 2'b00; rd_val = 32'h12345678;
      set_issue(0, 3'b001, 3, 0);
      run_txn("classic_read");
      set_issue(0, 3'b001, 0, 0);
      run_txn("zero_wait");
      set_issue(0, 3'b101, 1, 0);
      run_txn("err_ack");
      set_issue(0, 3'b010, 1, 0); set_issue(1, 3'b010, 0, 1); set_issue(2, 3'b001, 2, 1);
      run_txn("retry_ok");
      set_issue(2, 3'b010, 2, 0);
      run_txn("retry_fail");
      set_issue(0, 3'b000, 20, 0);
      run_txn("timeout");
      set_issue(0, 3'b001, 7, 3);
      run_txn("ack_at_timeout");
      set_issue(0, 3'b001, 8, 0);
      run_txn("ack_after_timeout");
      reset_mid();
      access = 2'b01; adr = 8'h44; wdata = 32'h0BADF00D; strobe = 4'h3;
      set_issue(0, 3'b001, 1, 1);
      run_txn("post_reset");
      for (int n = 0; n < 40; n++) begin
         access = 2'($urandom); adr = 8'($urandom); wdata = $urandom; strobe = 4'($urandom); rd_val = $urandom;
         for (int i = 0; i < 4; i++) begin
            int r;
            r = $urandom_range(0, 99);
            set_issue(i, r < 10 ? 3'b000 : r < 40 ? 3'b010 : 3'($urandom_range(1, 7)),
                      $urandom_range(0, 9), $urandom_range(0, 3));
         end
         run_txn($sformatf("rand%0d", n));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
